// File: rtl/grant_decoder_if.sv
// Grant handshake bundle for grant_decoder: index request, one-hot grant,
// per-target completion and status/error outputs.
interface grant_decoder_if #(
   parameter int N  = 3,
   parameter int IW = 2
);
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_idx;
   logic [N-1:0]  gnt;
   logic [N-1:0]  done;
   logic          busy;
   logic          err_idx;
   logic          err_timeout;
   logic [7:0]    gnt_cnt;

   modport slave (
      input  in_valid, in_idx, done,
      output in_ready, gnt, busy, err_idx, err_timeout, gnt_cnt
   );

   modport master (
      output in_valid, in_idx, done,
      input  in_ready, gnt, busy, err_idx, err_timeout, gnt_cnt
   );
endinterface

// File: rtl/grant_decoder.sv
// Decodes a registered request index into a held one-hot grant and runs the
// IDLE/GRANT/RELEASE handshake. Optional grant timeout: define GRANT_TIMEOUT_EN.
module grant_decoder #(
   parameter int N       = 3,
   parameter int IW      = 2,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   grant_decoder_if.slave bus
);

   if (N < 2 || N > 16 || (2 ** IW) < N || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("grant_decoder: illegal N/IW/TIMEOUT combination");
   end

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t        state, state_nx;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          in_ready_q, in_ready_d;
   logic          err_idx_q, err_idx_d;
   logic          err_to_q, err_to_d;
   logic          done_sel;
   logic          timeout_hit;

   assign done_sel = bus.done[idx_q];

`ifdef GRANT_TIMEOUT_EN
   logic [7:0] to_cnt;

   // Held at zero outside GRANT, so every entry into GRANT starts from zero.
   always_ff @(posedge clk) begin
      if (!rst_n)              to_cnt <= '0;
      else if (state != GRANT) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 8'd1;
   end

   // Fires on the edge that ends the TIMEOUT-th cycle of the grant.
   assign timeout_hit = (state == GRANT) && ((to_cnt + 8'd1) == 8'(TIMEOUT));
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         err_idx_q  <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         state      <= state_nx;
         gnt_q      <= gnt_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         err_idx_q  <= err_idx_d;
         err_to_q   <= err_to_d;
      end
   end

   // NOTE: every output of this block is defaulted first so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx  = state;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      err_idx_d = 1'b0;
      err_to_d  = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               if (int'(bus.in_idx) < N) begin
                  idx_d    = bus.in_idx;
                  gnt_d    = N'(1) << bus.in_idx;
                  state_nx = GRANT;
               end else begin
                  err_idx_d = 1'b1;
               end
            end
         end
         GRANT: begin
            // Completion takes precedence over a coincident timeout.
            if (done_sel) begin
               gnt_d    = '0;
               state_nx = RELEASE;
               cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else if (timeout_hit) begin
               gnt_d    = '0;
               err_to_d = 1'b1;
               state_nx = RELEASE;
            end
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      in_ready_d = (state_nx == IDLE);
   end

   assign bus.gnt         = gnt_q;
   assign bus.in_ready    = in_ready_q;
   assign bus.busy        = (state != IDLE);
   assign bus.err_idx     = err_idx_q;
   assign bus.err_timeout = err_to_q;
   assign bus.gnt_cnt     = cnt_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Directed self-checking bench for grant_decoder (N=3, IW=2, TIMEOUT=4);
// adapts the stall tests to whether GRANT_TIMEOUT_EN is defined.
module tb_grant_decoder;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

`ifdef GRANT_TIMEOUT_EN
   localparam int FOREIGN_CYCLES = 2;
`else
   localparam int FOREIGN_CYCLES = 5;
`endif

   grant_decoder_if #(.N(3), .IW(2)) bus ();

   grant_decoder #(.N(3), .IW(2), .TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle, so outputs are read away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Accept idx, hold done off for 'wait_cycles' grant cycles, then complete.
   task automatic do_grant(input logic [1:0] idx, input logic [2:0] exp_gnt, input int wait_cycles);
      bus.in_valid = 1'b1;
      bus.in_idx   = idx;
      step();
      bus.in_valid = 1'b0;
      check("grant_onehot", bus.gnt, exp_gnt);
      check("grant_busy", bus.busy, 1'b1);
      check("grant_not_ready", bus.in_ready, 1'b0);
      for (int i = 0; i < wait_cycles; i++) begin
         step();
         check("grant_held", bus.gnt, exp_gnt);
      end
      bus.done = exp_gnt;
      step();
      bus.done = '0;
      check("release_gnt", bus.gnt, 3'b000);
      check("release_busy", bus.busy, 1'b1);
      check("release_not_ready", bus.in_ready, 1'b0);
      step();
      check("idle_ready", bus.in_ready, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
   endtask

   initial begin
      n_cmp        = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd1;
      bus.done     = '0;

      // Reset held 3 cycles with a pending request.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_gnt", bus.gnt, 3'b000);
         check("rst_ready", bus.in_ready, 1'b0);
         check("rst_cnt", bus.gnt_cnt, 8'd0);
         check("rst_busy", bus.busy, 1'b0);
      end
      rst_n = 1'b1;
      step();
      check("post_rst_ready", bus.in_ready, 1'b1);
      check("post_rst_no_accept", bus.gnt, 3'b000);
      bus.in_valid = 1'b0;

      // Basic grants, done two cycles after gnt rises.
      do_grant(2'd0, 3'b001, 1);
      do_grant(2'd2, 3'b100, 1);
      do_grant(2'd1, 3'b010, 1);
      check("basic_cnt", bus.gnt_cnt, 8'd3);

      // Illegal index.
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd3;
      step();
      bus.in_valid = 1'b0;
      check("illegal_err", bus.err_idx, 1'b1);
      check("illegal_gnt", bus.gnt, 3'b000);
      check("illegal_ready", bus.in_ready, 1'b1);
      step();
      check("illegal_pulse_end", bus.err_idx, 1'b0);
      check("illegal_ready2", bus.in_ready, 1'b1);
      do_grant(2'd0, 3'b001, 0);
      check("illegal_cnt", bus.gnt_cnt, 8'd4);

      // Foreign done bits must be ignored.
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd1;
      step();
      bus.in_valid = 1'b0;
      bus.done     = 3'b101;
      check("foreign_gnt", bus.gnt, 3'b010);
      for (int i = 0; i < FOREIGN_CYCLES; i++) begin
         step();
         check("foreign_hold", bus.gnt, 3'b010);
         check("foreign_no_to", bus.err_timeout, 1'b0);
      end
      bus.done = 3'b010;
      step();
      bus.done = '0;
      check("foreign_drop", bus.gnt, 3'b000);
      step();
      check("foreign_ready", bus.in_ready, 1'b1);
      check("foreign_cnt", bus.gnt_cnt, 8'd5);

      // Stalled target on index 2.
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd2;
      step();
      bus.in_valid = 1'b0;
      check("stall_gnt", bus.gnt, 3'b100);
`ifdef GRANT_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         step();
         check("to_hold", bus.gnt, 3'b100);
         check("to_not_yet", bus.err_timeout, 1'b0);
      end
      step();
      check("to_pulse", bus.err_timeout, 1'b1);
      check("to_gnt_clear", bus.gnt, 3'b000);
      check("to_cnt_same", bus.gnt_cnt, 8'd5);
      check("to_busy", bus.busy, 1'b1);
      step();
      check("to_pulse_end", bus.err_timeout, 1'b0);
      check("to_ready", bus.in_ready, 1'b1);

      // done[2] arrives on the edge the timeout would fire.
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd2;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("coll_hold", bus.gnt, 3'b100);
      end
      bus.done = 3'b100;
      step();
      bus.done = '0;
      check("coll_no_to", bus.err_timeout, 1'b0);
      check("coll_gnt_clear", bus.gnt, 3'b000);
      check("coll_cnt", bus.gnt_cnt, 8'd6);
      step();
      check("coll_ready", bus.in_ready, 1'b1);
`else
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_forever", bus.gnt, 3'b100);
         check("hold_no_to", bus.err_timeout, 1'b0);
      end
      bus.done = 3'b100;
      step();
      bus.done = '0;
      check("hold_release", bus.gnt, 3'b000);
      check("hold_cnt", bus.gnt_cnt, 8'd6);
      step();
      check("hold_ready", bus.in_ready, 1'b1);
`endif

      // Reset in the middle of a grant aborts it and clears the counter.
      bus.in_valid = 1'b1;
      bus.in_idx   = 2'd1;
      step();
      bus.in_valid = 1'b0;
      check("abort_gnt", bus.gnt, 3'b010);
      rst_n = 1'b0;
      step();
      check("abort_gnt_clear", bus.gnt, 3'b000);
      check("abort_cnt_clear", bus.gnt_cnt, 8'd0);
      check("abort_ready", bus.in_ready, 1'b0);
      check("abort_busy", bus.busy, 1'b0);
      rst_n = 1'b1;
      step();
      check("abort_ready_back", bus.in_ready, 1'b1);

      // Saturation: 260 back-to-back minimum-period grants.
      for (int i = 0; i < 260; i++) begin
         do_grant(2'(i % 3), 3'(1 << (i % 3)), 0);
         if (i == 254) check("sat_reach", bus.gnt_cnt, 8'd255);
      end
      check("sat_hold", bus.gnt_cnt, 8'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
